// File: rtl/digital_clock_time_ctrl_if.sv
// Tick/button inputs and time/display outputs of the clock time controller.
// Port names follow the controller's own signal names; clock and reset stay outside.
interface digital_clock_time_ctrl_if;
  logic       tick_1hz;
  logic       tick_scan;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] hour_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic [1:0] mode;
  logic       min_pulse;
  logic [5:0] digit_sel;
  logic [3:0] digit_val;
  logic       digit_blank;

  modport master (
    output tick_1hz, tick_scan, btn_mode, btn_inc,
    input  hour_bcd, min_bcd, sec_bcd, mode, min_pulse,
    input  digit_sel, digit_val, digit_blank
  );

  modport slave (
    input  tick_1hz, tick_scan, btn_mode, btn_inc,
    output hour_bcd, min_bcd, sec_bcd, mode, min_pulse,
    output digit_sel, digit_val, digit_blank
  );
endinterface

// File: rtl/digital_clock_time_ctrl.sv
// HH:MM:SS BCD timekeeper with RUN/SET mode FSM and a 6-digit multiplexed
// 7-seg scan; every output is a register.
module digital_clock_time_ctrl #(
  parameter int HOUR_MAX = 23,
  parameter bit BLINK_EN = 1'b1
) (
  input logic                     fpga_clk,
  input logic                     rst,
  digital_clock_time_ctrl_if.slave bus
);

  localparam logic [7:0] HOUR_MAX_BCD = {4'(HOUR_MAX / 10), 4'(HOUR_MAX % 10)};

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_e;

  mode_e      state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       pulse_q, pulse_d;
  logic       blink_q, blink_d;
  logic [2:0] idx_q, idx_d;
  logic [5:0] sel_q, sel_d;
  logic [3:0] val_q, val_d;
  logic       blank_q, blank_d;
  mode_e      digit_field;

  // BCD increment that wraps to 00 once the field reaches max_v.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v == max_v)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pulse_d = 1'b0;
    blink_d = blink_q;
    idx_d   = idx_q;

    if (bus.btn_mode) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        SET_MIN:  state_d = SET_SEC;
        default:  state_d = RUN;
      endcase
    end

    // A mode press swallows a concurrent increment; a RUN tick still counts.
    case (state_q)
      RUN: begin
        if (bus.tick_1hz) begin
          sec_d = bcd_inc(sec_q, 8'h59);
          if (sec_q == 8'h59) begin
            pulse_d = 1'b1;
            min_d   = bcd_inc(min_q, 8'h59);
            if (min_q == 8'h59)
              hour_d = bcd_inc(hour_q, HOUR_MAX_BCD);
          end
        end
      end
      SET_HOUR: if (bus.btn_inc && !bus.btn_mode) hour_d = bcd_inc(hour_q, HOUR_MAX_BCD);
      SET_MIN:  if (bus.btn_inc && !bus.btn_mode) min_d = bcd_inc(min_q, 8'h59);
      default:  if (bus.btn_inc && !bus.btn_mode) sec_d = 8'h00;
    endcase

    if (state_q == SET_SEC && bus.btn_mode)
      blink_d = 1'b0;
    else if (bus.tick_1hz)
      blink_d = ~blink_q;

    if (bus.tick_scan)
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_sel
      assign sel_d[gi] = (idx_q == 3'(gi));
    end
  endgenerate

  always_comb begin
    val_d       = sec_q[3:0];
    digit_field = SET_SEC;
    case (idx_q)
      3'd1: begin val_d = sec_q[7:4];  digit_field = SET_SEC;  end
      3'd2: begin val_d = min_q[3:0];  digit_field = SET_MIN;  end
      3'd3: begin val_d = min_q[7:4];  digit_field = SET_MIN;  end
      3'd4: begin val_d = hour_q[3:0]; digit_field = SET_HOUR; end
      3'd5: begin val_d = hour_q[7:4]; digit_field = SET_HOUR; end
      default: ;
    endcase
    blank_d = BLINK_EN && blink_q && (state_q != RUN) && (state_q == digit_field);
  end

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      state_q <= RUN;
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      pulse_q <= 1'b0;
      blink_q <= 1'b0;
      idx_q   <= 3'd0;
      sel_q   <= 6'b000001;
      val_q   <= 4'd0;
      blank_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      pulse_q <= pulse_d;
      blink_q <= blink_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      val_q   <= val_d;
      blank_q <= blank_d;
    end
  end

  assign bus.hour_bcd    = hour_q;
  assign bus.min_bcd     = min_q;
  assign bus.sec_bcd     = sec_q;
  assign bus.mode        = state_q;
  assign bus.min_pulse   = pulse_q;
  assign bus.digit_sel   = sel_q;
  assign bus.digit_val   = val_q;
  assign bus.digit_blank = blank_q;

endmodule

// File: tb/tb_digital_clock_time_ctrl.sv
// Directed bench for the clock time controller: an integer reference model
// pushes expected outputs per step; they are popped and checked after the edge.
module tb_digital_clock_time_ctrl;

  logic fpga_clk = 1'b0;
  logic rst      = 1'b1;

  digital_clock_time_ctrl_if bus ();
  digital_clock_time_ctrl_if bus11 ();

  assign bus11.tick_1hz  = bus.tick_1hz;
  assign bus11.tick_scan = bus.tick_scan;
  assign bus11.btn_mode  = bus.btn_mode;
  assign bus11.btn_inc   = bus.btn_inc;

  digital_clock_time_ctrl #(.HOUR_MAX(23), .BLINK_EN(1'b1)) dut (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .bus      (bus.slave)
  );

  digital_clock_time_ctrl #(.HOUR_MAX(11), .BLINK_EN(1'b1)) dut11 (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .bus      (bus11.slave)
  );

  always #5 fpga_clk = ~fpga_clk;

  typedef struct {
    logic [7:0] h;
    logic [7:0] h11;
    logic [7:0] m;
    logic [7:0] s;
    logic [1:0] mode;
    logic       pulse;
    logic [5:0] sel;
    logic [3:0] val;
    logic       blank;
  } exp_t;

  exp_t sb_q[$];

  int compared   = 0;
  int mismatched = 0;
  int step_no    = 0;
  int pulse_seen = 0;

  int m_h = 0, m_h11 = 0, m_m = 0, m_s = 0, m_mode = 0, m_blink = 0, m_idx = 0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    compared++;
    assert (obs === exp_v)
    else begin
      mismatched++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp_v);
    end
  endtask

  task automatic step(input bit r, input bit t1, input bit ts, input bit bm, input bit bi);
    exp_t e;
    int   fld;
    int   d;
    rst           = r;
    bus.tick_1hz  = t1;
    bus.tick_scan = ts;
    bus.btn_mode  = bm;
    bus.btn_inc   = bi;

    if (r) begin
      m_h = 0; m_h11 = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0; m_idx = 0;
      e.sel = 6'b000001; e.val = 4'd0; e.blank = 1'b0; e.pulse = 1'b0;
    end else begin
      // Display registers sample the state as it stands before this edge.
      case (m_idx)
        0: d = m_s % 10;
        1: d = m_s / 10;
        2: d = m_m % 10;
        3: d = m_m / 10;
        4: d = m_h % 10;
        default: d = m_h / 10;
      endcase
      fld     = (m_idx < 2) ? 3 : (m_idx < 4) ? 2 : 1;
      e.sel   = 6'(1 << m_idx);
      e.val   = 4'(d);
      e.blank = (m_blink == 1) && (m_mode != 0) && (fld == m_mode);
      e.pulse = 1'b0;

      if (m_mode == 0 && t1) begin
        m_s++;
        if (m_s == 60) begin
          m_s = 0; e.pulse = 1'b1; m_m++;
          if (m_m == 60) begin
            m_m = 0;
            m_h   = (m_h == 23) ? 0 : m_h + 1;
            m_h11 = (m_h11 == 11) ? 0 : m_h11 + 1;
          end
        end
      end else if (m_mode != 0 && bi && !bm) begin
        if (m_mode == 1) begin
          m_h   = (m_h == 23) ? 0 : m_h + 1;
          m_h11 = (m_h11 == 11) ? 0 : m_h11 + 1;
        end else if (m_mode == 2) begin
          m_m = (m_m == 59) ? 0 : m_m + 1;
        end else begin
          m_s = 0;
        end
      end

      if (bm && m_mode == 3) m_blink = 0;
      else if (t1) m_blink = 1 - m_blink;
      if (bm) m_mode = (m_mode + 1) % 4;
      if (ts) m_idx = (m_idx + 1) % 6;
    end

    e.h = to_bcd(m_h); e.h11 = to_bcd(m_h11); e.m = to_bcd(m_m); e.s = to_bcd(m_s);
    e.mode = 2'(m_mode);
    sb_q.push_back(e);

    @(posedge fpga_clk);
    #1;
    bus.tick_1hz = 1'b0; bus.tick_scan = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    step_no++;

    e = sb_q.pop_front();
    $display("step %0d r=%0b t1=%0b ts=%0b bm=%0b bi=%0b -> %02h:%02h:%02h mode=%0d pulse=%0b sel=%06b val=%0d blank=%0b",
             step_no, r, t1, ts, bm, bi, bus.hour_bcd, bus.min_bcd, bus.sec_bcd, bus.mode,
             bus.min_pulse, bus.digit_sel, bus.digit_val, bus.digit_blank);
    chk("hour",      bus.hour_bcd,           e.h);
    chk("hour_h11",  bus11.hour_bcd,         e.h11);
    chk("min",       bus.min_bcd,            e.m);
    chk("sec",       bus.sec_bcd,            e.s);
    chk("mode",      {6'd0, bus.mode},       {6'd0, e.mode});
    chk("min_pulse", {7'd0, bus.min_pulse},  {7'd0, e.pulse});
    chk("digit_sel", {2'd0, bus.digit_sel},  {2'd0, e.sel});
    chk("digit_val", {4'd0, bus.digit_val},  {4'd0, e.val});
    chk("digit_blk", {7'd0, bus.digit_blank}, {7'd0, e.blank});
    if (bus.min_pulse === 1'b1) pulse_seen++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.tick_1hz = 1'b0; bus.tick_scan = 1'b0; bus.btn_mode = 1'b0; bus.btn_inc = 1'b0;
    @(posedge fpga_clk);
    #1;

    // Reset and one full minute of seconds.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    pulse_seen = 0;
    for (int i = 0; i < 60; i++) step(0, 1, 0, 0, 0);
    chk("t1_min_pulse_count", 8'(pulse_seen), 8'd1);
    chk("t1_min", bus.min_bcd, 8'h01);

    // Preload 23:59 (11:59 on the 12h part) via SET, then count to the day wrap.
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 23; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 58; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 59; i++) step(0, 1, 0, 0, 0);
    chk("t2_pre_hour", bus.hour_bcd, 8'h23);
    chk("t2_pre_h11", bus11.hour_bcd, 8'h11);
    step(0, 1, 0, 0, 0);
    chk("t2_wrap_pulse", {7'd0, bus.min_pulse}, 8'd1);
    chk("t2_wrap_h11", bus11.hour_bcd, 8'h00);

    // Tick together with mode in RUN, then set hour +5 and confirm time is frozen.
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    chk("t3_sec_frozen", bus.sec_bcd, 8'h01);
    chk("t3_hour", bus.hour_bcd, 8'h05);

    // Minute wrap with no carry; mode+inc drops the increment.
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 59; i++) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("t4_min_wrap", bus.min_bcd, 8'h00);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 1, 0);

    // Display scan: seven steps wrap the index.
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // Blink in SET_HOUR across all six digits, then the opposite phase.
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0, 0);

    // Reset mid-SET with every other input active.
    step(1, 1, 1, 1, 1);
    step(0, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
